result_bank: RTL and testbench

RESULT_BANK -- requirements
Module: result_bank

---
 rtl/result_bank.sv | 146 ++++++++++++++
 tb/tb_result_bank.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/result_bank.sv
// result_bank: 3x3 result matrix bank. Captures MAC result rows (three lanes
// per beat), then drains the stored matrix serially in row-major order over
// a valid/ready handshake, pulsing done after the final element is taken.
// Optional feature: define RESULT_BANK_LAST_EN to drive data_last on the
// final element; otherwise data_last is tied to 0.
module result_bank (
    input  logic       clk,
    input  logic       clear_res,
    input  logic [1:0] row_w,
    input  logic [1:0] col_x,
    input  logic       mac_valid,
    input  logic [9:0] res_in1,
    input  logic [9:0] res_in2,
    input  logic [9:0] res_in3,
    output logic       in_ready,
    output logic [9:0] data_out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       data_last,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nx;

    logic [9:0] mem [0:8];
    logic [1:0] rows;
    logic [1:0] cols;
    logic [1:0] r_cnt;
    logic [1:0] dr;
    logic [1:0] dc;

    logic       accept_first;
    logic       accept_fill;
    logic       wr_en;
    logic [1:0] wr_row;
    logic [1:0] wr_cols;
    logic [3:0] wr_base;
    logic [3:0] rd_idx;
    logic       at_last;
    logic       fire;

    // Beat acceptance, write addressing and drain-pointer decode
    always_comb begin
        accept_first = (state == IDLE) && mac_valid && (row_w != 2'd0) && (col_x != 2'd0);
        accept_fill  = (state == FILL) && mac_valid;
        wr_en        = accept_first || accept_fill;
        // The first beat must use the live dimensions; later beats use the latched ones
        wr_row       = accept_first ? 2'd0  : r_cnt;
        wr_cols      = accept_first ? col_x : cols;
        wr_base      = {1'b0, wr_row, 1'b0} + {2'b00, wr_row};
        rd_idx       = {1'b0, dr, 1'b0} + {2'b00, dr} + {2'b00, dc};
        at_last      = (dr == rows - 2'd1) && (dc == cols - 2'd1);
        fire         = (state == DRAIN) && out_ready;
    end

    // State register
    always_ff @(posedge clk) begin
        if (clear_res)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (accept_first) state_nx = (row_w == 2'd1) ? DRAIN : FILL;
            FILL:  if (mac_valid && (r_cnt == rows - 2'd1)) state_nx = DRAIN;
            DRAIN: if (fire && at_last) state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        in_ready  = (state == IDLE) || (state == FILL);
        out_valid = (state == DRAIN);
        data_out  = out_valid ? mem[rd_idx] : '0;
        done      = (state == DONE);
`ifdef RESULT_BANK_LAST_EN
        data_last = out_valid && at_last;
`else
        data_last = 1'b0;
`endif
    end

    // Storage, latched dimensions, fill counter and drain pointer
    always_ff @(posedge clk) begin
        if (clear_res) begin
            for (int unsigned i = 0; i < 9; i++)
                mem[i] <= '0;
            rows  <= '0;
            cols  <= '0;
            r_cnt <= '0;
            dr    <= '0;
            dc    <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_base] <= res_in1;
                if (wr_cols > 2'd1) mem[wr_base + 4'd1] <= res_in2;
                if (wr_cols > 2'd2) mem[wr_base + 4'd2] <= res_in3;
            end
            case (state)
                IDLE: begin
                    if (mac_valid) begin
                        rows <= row_w;
                        cols <= col_x;
                    end
                    if (accept_first)
                        r_cnt <= 2'd1;
                end
                FILL: begin
                    if (mac_valid)
                        r_cnt <= r_cnt + 2'd1;
                end
                DRAIN: begin
                    if (fire) begin
                        if (dc == cols - 2'd1) begin
                            dc <= '0;
                            dr <= dr + 2'd1;
                        end else begin
                            dc <= dc + 2'd1;
                        end
                    end
                end
                DONE: begin
                    r_cnt <= '0;
                    dr    <= '0;
                    dc    <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_result_bank.sv
// Directed testbench for result_bank. Expected data_last follows
// RESULT_BANK_LAST_EN when it is defined for the build.
module tb_result_bank;

    logic       clk = 1'b0;
    logic       clear_res;
    logic [1:0] row_w;
    logic [1:0] col_x;
    logic       mac_valid;
    logic [9:0] res_in1;
    logic [9:0] res_in2;
    logic [9:0] res_in3;
    logic       in_ready;
    logic [9:0] data_out;
    logic       out_valid;
    logic       out_ready;
    logic       data_last;
    logic       done;

    int passed = 0;
    int total  = 0;

`ifdef RESULT_BANK_LAST_EN
    localparam logic EXP_LAST = 1'b1;
`else
    localparam logic EXP_LAST = 1'b0;
`endif

    result_bank dut (
        .clk       (clk),
        .clear_res (clear_res),
        .row_w     (row_w),
        .col_x     (col_x),
        .mac_valid (mac_valid),
        .res_in1   (res_in1),
        .res_in2   (res_in2),
        .res_in3   (res_in3),
        .in_ready  (in_ready),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_last (data_last),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Checks the full output set while draining one element
    task automatic chk_elem(input string tag, input logic [9:0] val, input logic last);
        chk({tag, "_valid"}, {9'd0, out_valid}, 10'd1);
        chk({tag, "_data"},  data_out, val);
        chk({tag, "_last"},  {9'd0, data_last}, {9'd0, last});
    endtask

    task automatic beat(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
        mac_valid = 1'b1;
        res_in1 = a;
        res_in2 = b;
        res_in3 = c;
        step();
    endtask

    initial begin
        clear_res = 1'b1;
        row_w     = '0;
        col_x     = '0;
        mac_valid = 1'b0;
        res_in1   = '0;
        res_in2   = '0;
        res_in3   = '0;
        out_ready = 1'b1;
        step();
        step();
        clear_res = 1'b0;

        // Reset state
        chk("rst_in_ready",  {9'd0, in_ready},  10'd1);
        chk("rst_out_valid", {9'd0, out_valid}, 10'd0);
        chk("rst_data_out",  data_out,          10'd0);
        chk("rst_data_last", {9'd0, data_last}, 10'd0);
        chk("rst_done",      {9'd0, done},      10'd0);

        // 2x2 fill, then mac_valid with 1023 held during drain
        row_w = 2'd2;
        col_x = 2'd2;
        beat(10'd5, 10'd7, 10'd0);
        chk("fill2_in_ready",  {9'd0, in_ready},  10'd1);
        chk("fill2_out_valid", {9'd0, out_valid}, 10'd0);
        beat(10'd9, 10'd11, 10'd0);
        res_in1 = 10'd1023;
        res_in2 = 10'd1023;
        res_in3 = 10'd1023;
        chk("drain_in_ready", {9'd0, in_ready}, 10'd0);
        chk_elem("m2_e0", 10'd5, 1'b0);
        step();
        chk_elem("m2_e1", 10'd7, 1'b0);
        step();
        chk_elem("m2_e2", 10'd9, 1'b0);
        chk("drain_in_ready2", {9'd0, in_ready}, 10'd0);
        step();
        chk_elem("m2_e3", 10'd11, EXP_LAST);
        mac_valid = 1'b0;
        step();
        chk("m2_done",       {9'd0, done},      10'd1);
        chk("m2_done_valid", {9'd0, out_valid}, 10'd0);
        chk("m2_done_data",  data_out,          10'd0);
        chk("m2_done_inrdy", {9'd0, in_ready},  10'd0);
        step();
        chk("m2_idle_done",  {9'd0, done},      10'd0);
        chk("m2_idle_inrdy", {9'd0, in_ready},  10'd1);

        // 3x3 with two cycles of backpressure at element 4
        row_w = 2'd3;
        col_x = 2'd3;
        beat(10'd1, 10'd2, 10'd3);
        beat(10'd4, 10'd5, 10'd6);
        chk("m3_fill_valid", {9'd0, out_valid}, 10'd0);
        beat(10'd7, 10'd8, 10'd9);
        mac_valid = 1'b0;
        chk_elem("m3_e1", 10'd1, 1'b0);
        step();
        chk_elem("m3_e2", 10'd2, 1'b0);
        step();
        chk_elem("m3_e3", 10'd3, 1'b0);
        step();
        chk_elem("m3_e4", 10'd4, 1'b0);
        out_ready = 1'b0;
        step();
        chk_elem("m3_hold1", 10'd4, 1'b0);
        step();
        chk_elem("m3_hold2", 10'd4, 1'b0);
        out_ready = 1'b1;
        for (int k = 5; k <= 9; k++) begin
            step();
            chk_elem("m3_e", 10'(k), (k == 9) ? EXP_LAST : 1'b0);
        end
        step();
        chk("m3_done", {9'd0, done}, 10'd1);
        step();

        // Zero dimension beat is dropped
        row_w = 2'd0;
        col_x = 2'd3;
        beat(10'd50, 10'd51, 10'd52);
        chk("zero_in_ready",  {9'd0, in_ready},  10'd1);
        chk("zero_out_valid", {9'd0, out_valid}, 10'd0);
        step();
        chk("zero_out_valid2", {9'd0, out_valid}, 10'd0);
        mac_valid = 1'b0;
        step();

        // Reset in the middle of a 2x2 drain
        row_w = 2'd2;
        col_x = 2'd2;
        beat(10'd21, 10'd22, 10'd0);
        beat(10'd23, 10'd24, 10'd0);
        mac_valid = 1'b0;
        chk_elem("rd_e0", 10'd21, 1'b0);
        step();
        chk_elem("rd_e1", 10'd22, 1'b0);
        clear_res = 1'b1;
        step();
        clear_res = 1'b0;
        chk("rd_out_valid", {9'd0, out_valid}, 10'd0);
        chk("rd_in_ready",  {9'd0, in_ready},  10'd1);
        chk("rd_data_out",  data_out,          10'd0);
        row_w = 2'd1;
        col_x = 2'd1;
        beat(10'd0, 10'd0, 10'd0);
        mac_valid = 1'b0;
        chk_elem("rd_1x1", 10'd0, EXP_LAST);
        step();
        chk("rd_1x1_done", {9'd0, done}, 10'd1);
        step();

        // 1x3 fill: data_last only on the final element
        row_w = 2'd1;
        col_x = 2'd3;
        beat(10'd1, 10'd2, 10'd3);
        mac_valid = 1'b0;
        chk_elem("l_e0", 10'd1, 1'b0);
        step();
        chk_elem("l_e1", 10'd2, 1'b0);
        step();
        chk_elem("l_e2", 10'd3, EXP_LAST);
        step();
        chk("l_done",      {9'd0, done},      10'd1);
        chk("l_done_last", {9'd0, data_last}, 10'd0);
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
